multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore control FSM that drives every control line of the multicycle CPU datapath. It sequences the fetch, decode, execute, memory and writeback steps from the opcode and funct fields held in the instruction register. It decodes R-type funct directly into the 4-bit ALU operation code, counts retired instructions, and traps on illegal encodings.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
OPCODE_WIDTH, 6, opcode/funct field width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (gated in datapath)
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
MemtoReg  output  1  regfile write data: 0=ALUOut, 1=MDR
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
ALUOp  output  4  ALU operation code
ALUSrcB  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUSrcA  output  1  0=PC, 1=regA
RegWrite  output  1  regfile write enable
RegDst  output  1  write address: 0=rt, 1=rd
state  output  4  current state (debug)
trap  output  1  high while in TRAP
retired  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset is asynchronous and active-low. While reset=0: state=FETCH, retired=0, and all outputs are 0. Enables are gated by reset, so FETCH decode is not driven during reset.
- Outputs are a pure function of state, except ALUOp in EXEC, which also depends on funct. Any output not listed for a state is 0.
- ALUOp codes: ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0100, NOR=0101.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- Funct codes: add=100000, sub=100010, and=100100, or=100101, slt=101010, nor=100111.
- States, outputs and next state:
  - FETCH(0): MemRead, IRWrite, PCWrite, ALUSrcB=01, ADD -> DECODE.
  - DECODE(1): ALUSrcB=11, ADD (branch target into ALUOut).
    - LW/SW -> MEMADR; RTYPE with legal funct -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
    - Any other opcode, or RTYPE with an unlisted funct -> TRAP.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD -> MEMRD if LW, else MEMWR.
  - MEMRD(3): MemRead, IorD=1 -> MEMWB.
  - MEMWB(4): RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(5): MemWrite, IorD=1 -> FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=decode(funct) -> ALUWB.
  - ALUWB(7): RegWrite, RegDst=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=01 -> FETCH.
  - JUMP(9): PCWrite, PCSource=10 -> FETCH.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
  - ADDIWB(11): RegWrite, RegDst=0 -> FETCH.
  - TRAP(12): all controls 0, trap=1; remains in TRAP until reset.
  - Unused encodings 13-15 -> TRAP.
- Cycles per instruction: BEQ/J=3, RTYPE/ADDI/SW=4, LW=5.
- retired increments by 1 on each clock edge that leaves MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps from all-ones to 0. It never increments in TRAP.
- MemRead and MemWrite are never both 1. PCWrite and PCWriteCond are never both 1.
- Reset asserted mid-instruction aborts immediately. The first rising edge after release executes FETCH.
- opcode/funct are sampled only in DECODE and EXEC. Changes in other states have no effect.

Decomposition:
- Shared package multicycle_pkg holds:
  - state encoding constants (FETCH..TRAP),
  - opcode constants,
  - funct constants,
  - ALUOp constants,
  - ALUSrcB/PCSource select constants. The datapath uses the same package.
- One natural sub-module: alu_funct_decode. It is combinational, maps funct to ALUOp plus a legal flag, and is used by both EXEC and the DECODE legality check.

Test Plan:
- Reset held low 3 cycles, then release -> all controls 0 during reset; cycle 1 after release has state=0, MemRead=IRWrite=PCWrite=1, ALUSrcB=01, ALUOp=0000.
- opcode=100011 (LW) -> state sequence 0,1,2,3,4,0; MEMRD has IorD=1 and MemRead=1; MEMWB has MemtoReg=1 and RegWrite=1; retired 0->1 after 5 cycles.
- opcode=000000 with funct=100010, 100100, 101010 -> EXEC ALUOp=0001, 0010, 0100 respectively; ALUWB RegDst=1; 4 cycles each.
- opcode=000100 then 000010 -> BRANCH has PCWriteCond=1, PCSource=01, ALUOp=0001; JUMP has PCWrite=1, PCSource=10; retired +2 after 6 cycles.
- opcode=111111, and separately opcode=000000 with funct=000001 -> TRAP reached after DECODE; trap=1 and all controls 0 for 20 cycles; retired frozen; reset returns to FETCH.
- retired preset near wrap (CNT_WIDTH=4, 15 instructions, then one more) -> retired reads 15, then 0; reset asserted during MEMRD -> state=0 and retired=0 asynchronously.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle CPU control unit and datapath.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct to ALU operation decode, with a legality flag.
module alu_funct_decode
  import multicycle_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6
) (
  input  logic [FUNCT_WIDTH-1:0] funct,
  output logic [3:0]             alu_op,
  output logic                   legal
);

  // Map each supported funct to its ALU code; anything else is illegal.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_NOR:  alu_op = ALU_NOR;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle CPU datapath.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [OPCODE_WIDTH-1:0] funct,
  output logic                    PCWrite,
  output logic                    PCWriteCond,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    MemtoReg,
  output logic [1:0]              PCSource,
  output logic [3:0]              ALUOp,
  output logic [1:0]              ALUSrcB,
  output logic                    ALUSrcA,
  output logic                    RegWrite,
  output logic                    RegDst,
  output logic [3:0]              state,
  output logic                    trap,
  output logic [CNT_WIDTH-1:0]    retired
);

  state_t                state_q;
  state_t                state_d;
  logic                  is_lw_q;
  logic                  retire;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic [3:0]            fn_alu_op;
  logic                  fn_legal;

  alu_funct_decode #(.FUNCT_WIDTH(OPCODE_WIDTH)) u_fn_dec (
    .funct  (funct),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  // Opcode is only looked at in DECODE, so the LW/SW choice made in MEMADR
  // uses a flag captured there rather than the live opcode.
  assign retire = (state_q == MEMWB)  || (state_q == MEMWR) ||
                  (state_q == ALUWB)  || (state_q == BRANCH) ||
                  (state_q == JUMP)   || (state_q == ADDIWB);

  // State register, LW flag and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      is_lw_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_lw_q <= (opcode == OP_LW);
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Next-state and Moore outputs; every control forced low while in reset.
  always_comb begin
    state_d     = TRAP;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALU_ADD;
    ALUSrcB     = SRCB_REGB;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    trap        = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = fn_legal ? EXEC : TRAP;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = is_lw_q ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = fn_alu_op;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_d     = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        trap    = 1'b1;
        state_d = TRAP;
      end
      default: state_d = TRAP;
    endcase
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      PCSource    = '0;
      ALUOp       = '0;
      ALUSrcB     = '0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      trap        = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table-driven instruction
// vectors feeding a per-cycle scoreboard, plus trap/reset/wrap sequences.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp, state;
  logic        ALUSrcA, RegWrite, RegDst, trap;
  logic [31:0] retired;

  logic        w4_PCWrite, w4_PCWriteCond, w4_IorD, w4_MemRead, w4_MemWrite;
  logic        w4_IRWrite, w4_MemtoReg;
  logic [1:0]  w4_PCSource, w4_ALUSrcB;
  logic [3:0]  w4_ALUOp, w4_state;
  logic        w4_ALUSrcA, w4_RegWrite, w4_RegDst, w4_trap;
  logic [3:0]  w4_retired;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .trap(trap), .retired(retired)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .PCWrite(w4_PCWrite), .PCWriteCond(w4_PCWriteCond), .IorD(w4_IorD),
    .MemRead(w4_MemRead), .MemWrite(w4_MemWrite), .IRWrite(w4_IRWrite),
    .MemtoReg(w4_MemtoReg), .PCSource(w4_PCSource), .ALUOp(w4_ALUOp),
    .ALUSrcB(w4_ALUSrcB), .ALUSrcA(w4_ALUSrcA), .RegWrite(w4_RegWrite),
    .RegDst(w4_RegDst), .state(w4_state), .trap(w4_trap), .retired(w4_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle: pcw pcwc iord mr mw irw m2r pcsrc[2] aluop[4] srcb[2] srca rw rd trap
  logic [18:0] act_ctrl;
  assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite,
                     RegDst, trap};

  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, srca, rw, rd, tr;
    logic [1:0] pcsrc, srcb;
    logic [3:0] aop;
    {pcw, pcwc, iord, mr, mw, irw, m2r, srca, rw, rd, tr} = '0;
    pcsrc = 2'b00; srcb = 2'b00; aop = 4'b0000;
    case (st)
      4'd0:  begin pcw = 1; mr = 1; irw = 1; srcb = 2'b01; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin
        srca = 1;
        case (fn)
          6'b100010: aop = 4'b0001;
          6'b100100: aop = 4'b0010;
          6'b100101: aop = 4'b0011;
          6'b101010: aop = 4'b0100;
          6'b100111: aop = 4'b0101;
          default:   aop = 4'b0000;
        endcase
      end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin srca = 1; aop = 4'b0001; pcwc = 1; pcsrc = 2'b01; end
      4'd9:  begin pcw = 1; pcsrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: rw = 1;
      default: tr = 1;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, pcsrc, aop, srcb, srca, rw, rd, tr};
  endfunction

  typedef struct {
    logic [3:0]  st;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    int         path[6];
  } vec_t;

  exp_t        sbq[$];
  logic [31:0] model_ret = 0;
  vec_t        tbl[10];

  task automatic check_cycle(input exp_t e);
    logic [18:0] ec;
    ec = exp_ctrl(e.st, e.fn);
    checks++;
    if (state !== e.st || w4_state !== e.st) begin
      errors++;
      $display("FAIL state: got %0d/%0d want %0d", state, w4_state, e.st);
    end
    checks++;
    if (act_ctrl !== ec) begin
      errors++;
      $display("FAIL ctrl st=%0d: got %b want %b", e.st, act_ctrl, ec);
    end
    checks++;
    if (retired !== e.ret || w4_retired !== e.ret[3:0]) begin
      errors++;
      $display("FAIL retired st=%0d: got %0d/%0d want %0d", e.st, retired, w4_retired, e.ret);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    checks++;
    if (state !== 4'd0 || act_ctrl !== '0 || retired !== 32'd0 ||
        w4_state !== 4'd0 || w4_retired !== 4'd0) begin
      errors++;
      $display("FAIL %s: got st=%0d ctrl=%b ret=%0d ret4=%0d want all 0",
               tag, state, act_ctrl, retired, w4_retired);
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.len; i++) begin
      e.st = 4'(v.path[i]); e.op = v.op; e.fn = v.fn; e.ret = model_ret;
      sbq.push_back(e);
    end
    model_ret++;
  endtask

  task automatic push_trap(input logic [5:0] op, input logic [5:0] fn, input int n);
    exp_t e;
    e.op = op; e.fn = fn; e.ret = model_ret;
    e.st = 4'd0; sbq.push_back(e);
    e.st = 4'd1; sbq.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.st = 4'd12; sbq.push_back(e);
    end
  endtask

  // Called at a falling edge; opcode/funct are valid only where the FSM
  // samples them, random elsewhere.
  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.st == 4'd1 || e.st == 4'd6) begin
        opcode = e.op; funct = e.fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      check_cycle(e);
      @(negedge clk);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_reset_zero("reset_hold");
      @(negedge clk);
    end
    reset = 1'b1;
    model_ret = 0;
  endtask

  initial begin
    reset  = 1'b0;
    opcode = '0;
    funct  = '0;

    tbl[0] = '{6'b100011, 6'b000000, 5, '{0, 1, 2, 3, 4, 0}};
    tbl[1] = '{6'b101011, 6'b000000, 4, '{0, 1, 2, 5, 0, 0}};
    tbl[2] = '{6'b000000, 6'b100010, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[3] = '{6'b000000, 6'b100100, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[4] = '{6'b000000, 6'b101010, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[5] = '{6'b000000, 6'b100000, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[6] = '{6'b000000, 6'b100111, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[7] = '{6'b000100, 6'b000000, 3, '{0, 1, 8, 0, 0, 0}};
    tbl[8] = '{6'b000010, 6'b000000, 3, '{0, 1, 9, 0, 0, 0}};
    tbl[9] = '{6'b001000, 6'b000000, 4, '{0, 1, 10, 11, 0, 0}};

    // Reset held for three cycles, then every legal instruction class.
    apply_reset(3);
    for (int i = 0; i < 10; i++) push_vec(tbl[i]);
    drain();
    // OR funct as a second pass, back-to-back with BEQ/J.
    push_vec('{6'b000000, 6'b100101, 4, '{0, 1, 6, 7, 0, 0}});
    push_vec(tbl[7]);
    push_vec(tbl[8]);
    drain();

    // Illegal opcode: TRAP holds with counter frozen until reset.
    push_trap(6'b111111, 6'b000000, 20);
    drain();
    apply_reset(1);

    // RTYPE with unsupported funct.
    push_trap(6'b000000, 6'b000001, 20);
    drain();
    apply_reset(1);

    // Counter wrap on the 4-bit instance: 15 then 0.
    for (int i = 0; i < 15; i++) push_vec(tbl[8]);
    drain();
    #1;
    checks++;
    if (w4_retired !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre: got %0d want 15", w4_retired);
    end
    @(negedge clk);
    // one idle FETCH already elapsed; re-sync by treating it as the first J cycle
    begin
      exp_t e;
      e.op = 6'b000010; e.fn = 6'b0; e.ret = model_ret;
      e.st = 4'd1; sbq.push_back(e);
      e.st = 4'd9; sbq.push_back(e);
      model_ret++;
    end
    drain();
    #1;
    checks++;
    if (w4_retired !== 4'd0 || retired !== 32'd16) begin
      errors++;
      $display("FAIL wrap_post: got %0d/%0d want 0/16", w4_retired, retired);
    end
    @(negedge clk);
    // Previous FETCH cycle ran with random opcode; restart cleanly.
    apply_reset(1);

    // Asynchronous reset in the middle of MEMRD.
    push_vec(tbl[9]);
    begin
      exp_t e;
      e.op = 6'b100011; e.fn = 6'b0; e.ret = model_ret;
      e.st = 4'd0; sbq.push_back(e);
      e.st = 4'd1; sbq.push_back(e);
      e.st = 4'd2; sbq.push_back(e);
    end
    drain();
    #1;
    checks++;
    if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || retired !== 32'd1) begin
      errors++;
      $display("FAIL memrd_pre: got st=%0d mr=%b iord=%b ret=%0d want 3/1/1/1",
               state, MemRead, IorD, retired);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    model_ret = 0;
    push_vec(tbl[8]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
